// File: rtl/wb_ram_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone RAM arbiter.
package wb_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Next master index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared RAM.
interface wb_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9
);
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic                              s_ack_i;
  logic [DATA_WIDTH-1:0]             s_dat_i;

  modport arbiter (
    input  m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_stb_i, m_we_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o
  );

  modport slave (
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wb_ram_arbiter_rr_priority_picker.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req_vec,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   any_req
);
  int idx;

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    gnt_idx = '0;
    idx     = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (req_vec[idx]) gnt_idx = IDX_W'(idx);
    end
  end

  assign any_req = |req_vec;
endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one single-port Wishbone RAM between NUM_MASTERS
// requesters; one-cycle strobe per access, ack routed back, watchdog on hangs.
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_ram_arbiter_if.arbiter bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_n;
  logic [IDX_W-1:0]       grant_q, grant_n;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_n;
  logic [TMR_W-1:0]       timer_q, timer_n;

  logic                   acked, timed_out, finish;
  logic [IDX_W-1:0]       grant_inc, pick_ptr, gnt_idx;
  logic [NUM_MASTERS-1:0] req_vec;
  logic                   any_req;

  logic [NUM_MASTERS-1:0] m_ack, m_err;
  logic [DATA_WIDTH-1:0]  m_dat, s_dat;
  logic [ADDR_WIDTH-1:0]  s_adr;
  logic                   s_stb, s_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_n;
      grant_q  <= grant_n;
      rr_ptr_q <= rr_ptr_n;
      timer_q  <= timer_n;
    end
  end

  // The finishing master still holds stb in its ack/err cycle, so it is masked
  // and the search restarts just past it.
  always_comb begin
    acked     = (state_q == ST_WAIT) && bus.s_ack_i;
    timed_out = (state_q == ST_WAIT) && !bus.s_ack_i && (timer_q == TMR_LAST);
    finish    = acked || timed_out;
    grant_inc = IDX_W'(wrap_inc(int'(grant_q), NUM_MASTERS));
    req_vec   = bus.m_stb_i;
    if (finish) req_vec[grant_q] = 1'b0;
    pick_ptr  = finish ? grant_inc : rr_ptr_q;
  end

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req_vec(req_vec),
    .rr_ptr (pick_ptr),
    .gnt_idx(gnt_idx),
    .any_req(any_req)
  );

  always_comb begin
    state_n  = state_q;
    grant_n  = grant_q;
    rr_ptr_n = rr_ptr_q;
    timer_n  = timer_q;
    m_ack    = '0;
    m_err    = '0;
    m_dat    = '0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat    = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_REQ;
          grant_n = gnt_idx;
          timer_n = '0;
        end
      end
      ST_REQ: begin
        state_n = ST_WAIT;
        s_stb   = 1'b1;
        s_we    = bus.m_we_i[grant_q];
        s_adr   = bus.m_adr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat   = bus.m_dat_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      end
      ST_WAIT: begin
        timer_n = timer_q + 1'b1;
        if (acked) begin
          m_ack[grant_q] = 1'b1;
          m_dat          = bus.s_dat_i;
          rr_ptr_n       = grant_inc;
          if (any_req) begin
            state_n = ST_REQ;
            grant_n = gnt_idx;
            timer_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (timed_out) begin
          m_err[grant_q] = 1'b1;
          rr_ptr_n       = grant_inc;
          state_n        = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.m_ack_o = m_ack;
  assign bus.m_err_o = m_err;
  assign bus.m_dat_o = m_dat;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = s_we;
  assign bus.s_adr_o = s_adr;
  assign bus.s_dat_o = s_dat;
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios plus random batches checked
// against a round-robin service-order model and a reference memory image.
module tb_wb_ram_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_ram_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Behavioural single-port RAM with registered ack.
  logic [DW-1:0] ram [512];
  logic          ram_init  = 1'b1;
  logic          ack_en    = 1'b1;
  logic          force_ack = 1'b0;
  logic          ack_q     = 1'b0;
  logic [DW-1:0] rd_q      = '0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= DW'(i) ^ 8'h5A;
      ram[5] <= 8'hA5;
    end else begin
      ack_q <= (bus.s_stb_o && ack_en) || force_ack;
      if (bus.s_stb_o && ack_en) begin
        rd_q <= ram[bus.s_adr_o];
        if (bus.s_we_o) ram[bus.s_adr_o] <= bus.s_dat_o;
      end
    end
  end
  assign bus.s_ack_i = ack_q;
  assign bus.s_dat_i = rd_q;

  // Reference state
  logic [DW-1:0] mdl [512];
  logic [AW-1:0] madr [N];
  logic          mwe  [N];
  logic [DW-1:0] mdat [N];
  int            ptr_m = 0;
  logic [N-1:0]  drop_next = '0;
  int            checks = 0;
  int            fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.m_stb_i = bus.m_stb_i & ~drop_next;
    drop_next   = '0;
  endtask

  task automatic set_master(input int k, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat);
    mwe[k] = we; madr[k] = adr; mdat[k] = dat;
    bus.m_we_i[k]            = we;
    bus.m_adr_i[k*AW +: AW]  = adr;
    bus.m_dat_i[k*DW +: DW]  = dat;
  endtask

  function automatic int next_req(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++) if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_stb"}, 32'(bus.s_stb_o), 32'd0);
    chk({tag, "_ack"}, 32'(bus.m_ack_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.m_err_o), 32'd0);
    chk({tag, "_dat"}, 32'(bus.m_dat_o), 32'd0);
  endtask

  // All masters in mask raise stb together from IDLE and drop it after their ack.
  task automatic run_batch(input logic [N-1:0] mask);
    int            order[$];
    logic [DW-1:0] rdv[$];
    logic [N-1:0]  exp_ack;
    int            n, k;
    for (int i = 0; i < N; i++) if (mask[(ptr_m + i) % N]) order.push_back((ptr_m + i) % N);
    foreach (order[j]) begin
      k = order[j];
      if (mwe[k]) mdl[madr[k]] = mdat[k];
      rdv.push_back(mdl[madr[k]]);
    end
    n = order.size();
    bus.m_stb_i = mask;
    for (int s = 1; s <= 2*n + 1; s++) begin
      tick();
      exp_ack = '0;
      if (s % 2 == 0) exp_ack[order[s/2 - 1]] = 1'b1;
      chk("s_stb", 32'(bus.s_stb_o), 32'(s % 2 == 1 && s < 2*n));
      if (s % 2 == 1 && s < 2*n) begin
        chk("s_adr", 32'(bus.s_adr_o), 32'(madr[order[s/2]]));
        chk("s_we",  32'(bus.s_we_o),  32'(mwe[order[s/2]]));
        if (mwe[order[s/2]]) chk("s_dat", 32'(bus.s_dat_o), 32'(mdat[order[s/2]]));
      end else begin
        chk("s_adr_idle", 32'(bus.s_adr_o), 32'd0);
      end
      chk("m_ack", 32'(bus.m_ack_o), 32'(exp_ack));
      chk("m_err", 32'(bus.m_err_o), 32'd0);
      if (exp_ack == '0) chk("m_dat_idle", 32'(bus.m_dat_o), 32'd0);
      else if (!mwe[order[s/2 - 1]]) chk("m_rdata", 32'(bus.m_dat_o), 32'(rdv[s/2 - 1]));
      drop_next = exp_ack;
    end
    ptr_m = (order[n-1] + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int            seq[8];
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  mask;
    logic [AW-1:0] adr;
    for (int i = 0; i < 512; i++) mdl[i] = DW'(i) ^ 8'h5A;
    mdl[5] = 8'hA5;
    bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
    for (int k = 0; k < N; k++) set_master(k, 1'b0, '0, '0);

    // Reset state
    #12;
    chk_quiet("reset");
    ram_init = 1'b0;
    #5 rst = 1'b0;

    // Contention from reset: m0 then m1
    set_master(0, 1'b0, 9'h010, 8'h00);
    set_master(1, 1'b0, 9'h011, 8'h00);
    run_batch(3'b011);

    // Single read, 0xA5 at 0x005
    set_master(0, 1'b0, 9'h005, 8'h00);
    run_batch(3'b001);

    // Fairness: m0 and m1 held for 8 accesses
    set_master(0, 1'b0, 9'h020, 8'h00);
    set_master(1, 1'b0, 9'h021, 8'h00);
    for (int a = 0; a < 8; a++) begin
      seq[a] = next_req(3'b011, ptr_m);
      ptr_m  = (seq[a] + 1) % N;
    end
    bus.m_stb_i = 3'b011;
    for (int s = 1; s <= 16; s++) begin
      tick();
      exp_ack = '0;
      if (s % 2 == 0) exp_ack[seq[s/2 - 1]] = 1'b1;
      chk("fair_stb", 32'(bus.s_stb_o), 32'(s % 2));
      if (s % 2 == 1) chk("fair_adr", 32'(bus.s_adr_o), 32'(madr[seq[s/2]]));
      chk("fair_ack", 32'(bus.m_ack_o), 32'(exp_ack));
      if (s % 2 == 0) chk("fair_dat", 32'(bus.m_dat_o), 32'(mdl[madr[seq[s/2 - 1]]]));
    end
    bus.m_stb_i = '0;
    tick();
    chk_quiet("fair_end");

    // Write then read at the top address
    set_master(1, 1'b1, 9'h1FF, 8'h3C);
    run_batch(3'b010);
    set_master(0, 1'b0, 9'h1FF, 8'h00);
    run_batch(3'b001);
    chk("wr_rd_model", 32'(mdl[9'h1FF]), 32'h3C);

    // Timeout with the slave silent, then a late ack
    ack_en = 1'b0;
    set_master(2, 1'b0, 9'h0AA, 8'h00);
    bus.m_stb_i = 3'b100;
    for (int s = 1; s <= TO + 2; s++) begin
      tick();
      chk("to_stb", 32'(bus.s_stb_o), 32'(s == 1));
      chk("to_err", 32'(bus.m_err_o), (s == TO + 1) ? 32'h4 : 32'h0);
      chk("to_ack", 32'(bus.m_ack_o), 32'd0);
      if (s == TO + 1) drop_next = 3'b100;
    end
    ptr_m = (2 + 1) % N;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk_quiet("late_ack");
    tick();
    chk_quiet("late_ack2");
    ack_en = 1'b1;
    run_batch(3'b100);

    // Async reset during REQ: strobe drops at once
    set_master(1, 1'b0, 9'h033, 8'h00);
    bus.m_stb_i = 3'b010;
    tick();
    chk("rstq_stb_pre", 32'(bus.s_stb_o), 32'd1);
    #2 rst = 1'b1;
    #1 chk_quiet("rst_req");
    chk("rst_req_adr", 32'(bus.s_adr_o), 32'd0);
    bus.m_stb_i = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Async reset during WAIT with ack showing: outputs clear at once
    set_master(2, 1'b0, 9'h044, 8'h00);
    bus.m_stb_i = 3'b100;
    tick();
    tick();
    chk("rstw_ack_pre", 32'(bus.m_ack_o), 32'h4);
    #2 rst = 1'b1;
    #1 chk_quiet("rst_wait");
    bus.m_stb_i = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_quiet("post_rst");
    end
    ptr_m = 0;
    set_master(0, 1'b0, 9'h050, 8'h00);
    set_master(1, 1'b0, 9'h051, 8'h00);
    set_master(2, 1'b0, 9'h052, 8'h00);
    run_batch(3'b111);

    // Random batches
    for (int b = 0; b < 30; b++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (mask[k]) begin
          adr = AW'($urandom_range(0, 7));
          if ($urandom_range(0, 4) == 0) adr = 9'h1FF;
          set_master(k, 1'($urandom_range(0, 1)), adr, DW'($urandom));
        end
      end
      run_batch(mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
